// File: rtl/seg7_if.sv
// seg7_if: CPU-side load bus and display pins of the multiplexed 7-segment scanner
// master drives load/value/dp_in/blank_lz (and blink_mask with SEG7_BLINK_EN), sees led/an
// slave is the scanner side
interface seg7_if #(parameter int DIGITS = 4);
  logic load;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dp_in;
  logic blank_lz;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0] blink_mask;
`endif
  logic [7:0] led;
  logic [DIGITS-1:0] an;
  modport master (
`ifdef SEG7_BLINK_EN
    output blink_mask,
`endif
    output load, value, dp_in, blank_lz,
    input led, an
  );
  modport slave (
`ifdef SEG7_BLINK_EN
    input blink_mask,
`endif
    input load, value, dp_in, blank_lz,
    output led, an
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed DIGITS-digit common-anode 7-segment driver with dead time and leading-zero blanking
// ports: clk, rst (async, active-high), io (seg7_if.slave: load/value/dp_in/blank_lz in, led/an out, active-low)
// optional macro SEG7_BLINK_EN adds BLINK_FRAMES and io.blink_mask (masked digits dark on odd blink phase)
module seg7_scan #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int DEAD = 1
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input logic clk,
  input logic rst,
  seg7_if.slave io
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };
  logic [4*DIGITS-1:0] sval;
  logic [DIGITS-1:0] sdp;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic [DIGITS-1:0] lz;
  logic z;
  logic [6:0] seg;
  logic wrap, last, dead, dark;
  always_comb begin
    nib = 4'h0;
    lz = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (sval[4*i +: 4] == 4'h0);
      lz[i] = z;
      if (IW'(i) == idx) nib = sval[4*i +: 4];
    end
    seg = (io.blank_lz && idx != '0 && lz[idx]) ? 7'h7F : SEG[nib];
    wrap = cnt == CW'(PRESCALE - 1);
    last = idx == IW'(DIGITS - 1);
    dead = cnt < CW'(DEAD);
  end
`ifdef SEG7_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [DIGITS-1:0] smask;
  logic [FW-1:0] fcnt;
  logic phase;
  assign dark = phase & smask[idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      smask <= '0;
      fcnt <= '0;
      phase <= 1'b0;
    end else begin
      if (io.load) smask <= io.blink_mask;
      if (wrap && last) begin
        fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
        if (fcnt == FW'(BLINK_FRAMES - 1)) phase <= ~phase;
      end
    end
`else
  assign dark = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sval <= '0;
      sdp <= '0;
      cnt <= '0;
      idx <= '0;
      io.led <= 8'hFF;
      io.an <= '1;
    end else begin
      if (io.load) begin
        sval <= io.value;
        sdp <= io.dp_in;
      end
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= last ? '0 : idx + 1'b1;
      io.led <= (dead || dark) ? 8'hFF : {~sdp[idx], seg};
      io.an <= dead ? '1 : ~(DIGITS'(1) << idx);
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with DIGITS=4, PRESCALE=4, DEAD=1
module tb_seg7_scan;
  logic clk, rst;
  int checks = 0;
  int failures = 0;
  int p = 0;
  logic [11:0] q [$];
  seg7_if #(.DIGITS(4)) io ();
  seg7_scan #(.DIGITS(4), .PRESCALE(4), .DEAD(1)
`ifdef SEG7_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (.clk(clk), .rst(rst), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({io.an, io.led} !== e)
        begin
          failures++;
          $display("FAIL scan#%0d got an=%h led=%h want an=%h led=%h", checks, io.an, io.led, e[11:8], e[7:0]);
        end
    end
  end
  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got an=%h led=%h want an=%h led=%h", name, got[11:8], got[7:0], want[11:8], want[7:0]);
    end
  endtask
  task automatic run(input logic [31:0] tab, input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] a;
      a = 4'b0001 << (p / 4);
      q.push_back(p % 4 == 0 ? 12'hFFF : {~a, tab[8*(p/4) +: 8]});
      @(negedge clk);
      p = (p + 1) % 16;
    end
  endtask
  initial begin
    rst = 1'b1;
    io.load = 1'b0;
    io.value = '0;
    io.dp_in = '0;
    io.blank_lz = 1'b0;
`ifdef SEG7_BLINK_EN
    io.blink_mask = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_init", {io.an, io.led}, 12'hFFF);
    rst = 1'b0;
    p = 0;
    io.load = 1'b1;
    io.value = 16'h1234;
    run({8'hF9, 8'hA4, 8'hB0, 8'h99}, 1);
    io.load = 1'b0;
    run({8'hF9, 8'hA4, 8'hB0, 8'h99}, 41);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_midscan", {io.an, io.led}, 12'hFFF);
    @(negedge clk);
    chk("reset_held", {io.an, io.led}, 12'hFFF);
    rst = 1'b0;
    p = 0;
    io.load = 1'b1;
    io.value = 16'h0005;
    io.blank_lz = 1'b1;
    run({8'hFF, 8'hFF, 8'hFF, 8'h92}, 1);
    io.load = 1'b0;
    run({8'hFF, 8'hFF, 8'hFF, 8'h92}, 21);
    io.blank_lz = 1'b0;
    run({8'hC0, 8'hC0, 8'hC0, 8'h92}, 10);
    io.load = 1'b1;
    io.value = 16'h0000;
    io.dp_in = 4'b0100;
    io.blank_lz = 1'b1;
    run(32'hFFFF_FFFF, 1);
    io.load = 1'b0;
    run({8'hFF, 8'h7F, 8'hFF, 8'hC0}, 15);
    io.load = 1'b1;
    io.value = 16'hABCD;
    io.dp_in = 4'b0000;
    io.blank_lz = 1'b0;
    run(32'hFFFF_FFFF, 1);
    io.load = 1'b0;
    run({8'h88, 8'h83, 8'hA7, 8'hA1}, 21);
    io.load = 1'b1;
    io.value = 16'hEF09;
    run({8'h88, 8'h83, 8'hA7, 8'hA1}, 1);
    io.load = 1'b0;
    run({8'h86, 8'h8E, 8'hC0, 8'h90}, 25);
`ifdef SEG7_BLINK_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p = 0;
    io.load = 1'b1;
    io.value = 16'h1111;
    io.blink_mask = 4'b0001;
    run({8'hF9, 8'hF9, 8'hF9, 8'hF9}, 1);
    io.load = 1'b0;
    run({8'hF9, 8'hF9, 8'hF9, 8'hF9}, 31);
    run({8'hF9, 8'hF9, 8'hF9, 8'hFF}, 32);
    run({8'hF9, 8'hF9, 8'hF9, 8'hF9}, 16);
`endif
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
